// File: rtl/rvee_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rvee_pkg                                                             |
// | Shared privilege, interrupt-cause and controller-state definitions.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rvee_pkg;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam int IRQ_SSI        = 1;
  localparam int IRQ_MSI        = 3;
  localparam int IRQ_STI        = 5;
  localparam int IRQ_MTI        = 7;
  localparam int IRQ_SEI        = 9;
  localparam int IRQ_MEI        = 11;
  localparam int IRQ_LOCAL_BASE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/rvee_irq_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rvee_irq_prio                                                        |
// | Fixed-priority interrupt selector: MEI>MSI>MTI>SEI>SSI>STI>locals.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rvee_irq_prio
  import rvee_pkg::*;
#(
  parameter int N_SRC = 32,
  parameter int CW    = 31
) (
  input  logic [N_SRC-1:0] elig_i,
  output logic             valid_o,
  output logic [CW-1:0]    cause_o
);

  // Later assignments win, so sources are visited from lowest to highest priority.
  always_comb begin
    valid_o = |elig_i;
    cause_o = '0;
    for (int i = N_SRC - 1; i >= IRQ_LOCAL_BASE; i--) begin
      if (elig_i[i]) cause_o = CW'(i);
    end
    if (elig_i[IRQ_STI]) cause_o = CW'(IRQ_STI);
    if (elig_i[IRQ_SSI]) cause_o = CW'(IRQ_SSI);
    if (elig_i[IRQ_SEI]) cause_o = CW'(IRQ_SEI);
    if (elig_i[IRQ_MTI]) cause_o = CW'(IRQ_MTI);
    if (elig_i[IRQ_MSI]) cause_o = CW'(IRQ_MSI);
    if (elig_i[IRQ_MEI]) cause_o = CW'(IRQ_MEI);
  end

endmodule
`default_nettype wire

// File: rtl/rvee_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rvee_irq_ctrl                                                        |
// | M/S interrupt controller with local lines, delegation and hold-off.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rvee_irq_ctrl
  import rvee_pkg::*;
#(
  parameter int                 XLEN        = 32,
  parameter int                 N_LOCAL     = 16,
  parameter logic [N_LOCAL-1:0] EDGE_MASK   = '0,
  parameter int                 HOLDOFF_CYC = 2,
  localparam int                N_SRC       = 16 + N_LOCAL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               meip,
  input  logic               msip,
  input  logic               mtip,
  input  logic               seip,
  input  logic               ssip,
  input  logic               stip,
  input  logic [N_LOCAL-1:0] local_irq,
  input  logic [1:0]         mode,
  input  logic               mstatus_mie,
  input  logic               mstatus_sie,
  input  logic [N_SRC-1:0]   mie_r,
  input  logic [N_SRC-1:0]   mideleg,
  input  logic               csr_clr_en,
  input  logic [N_LOCAL-1:0] csr_clr_mask,
  input  logic               irq_take,
  output logic               irq_req,
  output logic [XLEN-2:0]    irq_cause,
  output logic [1:0]         irq_mode,
  output logic [N_SRC-1:0]   pend_vec
);

  localparam int CW = XLEN - 1;

  irq_state_t         state_q, state_d;
  logic               req_q, req_d;
  logic [CW-1:0]      cause_q, cause_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [N_LOCAL-1:0] latch_q, latch_d;
  logic [N_LOCAL-1:0] prev_q;

  logic               take_acc;
  logic [N_LOCAL-1:0] edge_set;
  logic [N_LOCAL-1:0] edge_clr;
  logic               m_ok, s_ok;
  logic [N_SRC-1:0]   m_elig, s_elig;
  logic               m_valid, s_valid;
  logic [CW-1:0]      m_cause, s_cause;
  logic               cand;
  logic [CW-1:0]      best_cause;
  logic [1:0]         best_mode;

  assign take_acc = (state_q == REQ) && irq_take;
  assign edge_set = local_irq & ~prev_q;

  // A new edge beats a clear arriving in the same cycle.
  always_comb begin
    edge_clr = '0;
    latch_d  = '0;
    for (int i = 0; i < N_LOCAL; i++) begin
      edge_clr[i] = (csr_clr_en & csr_clr_mask[i])
                  | (take_acc && (cause_q == CW'(IRQ_LOCAL_BASE + i)));
      latch_d[i]  = EDGE_MASK[i] & (edge_set[i] | (latch_q[i] & ~edge_clr[i]));
    end
  end

  always_comb begin
    pend_vec          = '0;
    pend_vec[IRQ_SSI] = ssip;
    pend_vec[IRQ_MSI] = msip;
    pend_vec[IRQ_STI] = stip;
    pend_vec[IRQ_MTI] = mtip;
    pend_vec[IRQ_SEI] = seip;
    pend_vec[IRQ_MEI] = meip;
    for (int i = 0; i < N_LOCAL; i++) begin
      pend_vec[IRQ_LOCAL_BASE + i] = EDGE_MASK[i] ? latch_q[i] : local_irq[i];
    end
  end

  assign m_ok   = (mode != PRIV_M) | mstatus_mie;
  assign s_ok   = (mode == PRIV_U) | ((mode == PRIV_S) & mstatus_sie);
  assign m_elig = pend_vec & mie_r & ~mideleg & {N_SRC{m_ok}};
  assign s_elig = pend_vec & mie_r &  mideleg & {N_SRC{s_ok}};

  rvee_irq_prio #(.N_SRC(N_SRC), .CW(CW)) u_prio_m (
    .elig_i  (m_elig),
    .valid_o (m_valid),
    .cause_o (m_cause)
  );

  rvee_irq_prio #(.N_SRC(N_SRC), .CW(CW)) u_prio_s (
    .elig_i  (s_elig),
    .valid_o (s_valid),
    .cause_o (s_cause)
  );

  assign cand       = m_valid | s_valid;
  assign best_cause = m_valid ? m_cause : s_cause;
  assign best_mode  = m_valid ? PRIV_M : PRIV_S;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    cause_d = cause_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cand) begin
          state_d = REQ;
          req_d   = 1'b1;
          cause_d = best_cause;
          mode_d  = best_mode;
        end
      end
      REQ: begin
        // Decode consumes the cause it saw in the take cycle, so it is frozen here.
        if (irq_take) begin
          state_d = HOLD;
          cnt_d   = 4'(HOLDOFF_CYC);
        end else if (!cand) begin
          state_d = IDLE;
        end else begin
          req_d   = 1'b1;
          cause_d = best_cause;
          mode_d  = best_mode;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cause_q <= '0;
      mode_q  <= PRIV_M;
      cnt_q   <= '0;
      latch_q <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cause_q <= cause_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      prev_q  <= local_irq;
    end
  end

  assign irq_req   = req_q;
  assign irq_cause = cause_q;
  assign irq_mode  = mode_q;

endmodule
`default_nettype wire
